multi_digit_7seg_scan: RTL

Parametrised N-digit multiplexed seven-segment driver, the successor to the two-digit score display. It latches an N-digit BCD/hex word on a load strobe and scans one digit per slot. Per slot it applies an anti-ghosting blank gap, optional leading-zero blanking, per-digit blink and per-digit decimal point. It sits between the game/score logic and the board's common-anode display pins. All outputs are registered and active-low.

---
 rtl/multi_digit_7seg_scan.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/multi_digit_7seg_scan.sv
// Multiplexed N-digit seven-segment driver for common-anode displays.
// A load strobe captures the digit word into a shadow register. The scan
// then shows one digit per slot. Each slot opens with a dark gap against
// ghosting, and the driver also handles leading-zero blanking, per-digit
// blink and per-digit decimal point. All outputs are registered and
// active-low.
module multi_digit_7seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 4,
  parameter int GAP        = 1,
  parameter int BLINK_HALF = 250
) (
  input  logic                    clk_1k,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    lz_blank_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int CW = $clog2(DWELL);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [4*NUM_DIGITS-1:0] r_value_q;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [BW-1:0]           r_bcnt;
  logic                    r_blink_off;

  logic [NUM_DIGITS-1:0]   w_lz;
  logic [3:0]              w_nib;
  logic                    w_lz_cur;
  logic                    w_blink_cur;
  logic                    w_dp_cur;
  logic                    w_gap;
  logic                    w_dark;
  logic                    w_cnt_wrap;
  logic                    w_bcnt_wrap;

  // Hex glyphs, active-low, seg[0]=a .. seg[6]=g.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // Leading-zero map: digit i blanks when it and every higher nibble are zero.
  always_comb begin
    logic z;
    w_lz = '0;
    z    = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      z       = z & (r_value_q[4*i +: 4] == 4'h0);
      w_lz[i] = z & lz_blank_en;
    end
  end

  // Select the attributes of the digit currently being scanned.
  always_comb begin
    w_nib       = 4'h0;
    w_lz_cur    = 1'b0;
    w_blink_cur = 1'b0;
    w_dp_cur    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib       = r_value_q[4*i +: 4];
        w_lz_cur    = w_lz[i];
        w_blink_cur = blink_mask[i];
        w_dp_cur    = dp_mask[i];
      end
    end
  end

  assign w_gap       = (int'(r_cnt) < GAP);
  assign w_dark      = w_gap | w_lz_cur | (w_blink_cur & r_blink_off);
  assign w_cnt_wrap  = (r_cnt == CW'(DWELL - 1));
  assign w_bcnt_wrap = (r_bcnt == BW'(BLINK_HALF - 1));

  // Shadow register: only the latched word is displayed.
  always_ff @(posedge clk_1k) begin
    if (!rst_n)    r_value_q <= '0;
    else if (load) r_value_q <= value;
  end

  // Slot and digit counters, plus a free-running blink phase.
  always_ff @(posedge clk_1k) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_bcnt      <= '0;
      r_blink_off <= 1'b0;
    end else begin
      if (w_cnt_wrap) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_bcnt_wrap) begin
        r_bcnt      <= '0;
        r_blink_off <= ~r_blink_off;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  // Output register, one cycle behind the counters. An anode is driven only
  // when the slot is lit, so two anodes are never low at the same time.
  always_ff @(posedge clk_1k) begin
    if (!rst_n || w_dark) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= ~(NUM_DIGITS'(1) << r_idx);
      seg <= glyph(w_nib);
      dp  <= ~w_dp_cur;
    end
  end

endmodule
